// File: rtl/avalon_burst_arbiter_pkg.sv
// Shared types and bus constants for the Avalon-MM burst arbiter.
package avalon_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

   localparam int AV_DATA_W  = 32;
   localparam int AV_BE_W    = 4;
   localparam int AV_BURST_W = 8;

endpackage

// File: rtl/avalon_burst_arbiter_picker.sv
// Request picker: round-robin after the last granted index, or lowest-index-wins
// when AVALON_ARB_FIXED_PRIO_EN is defined.
module rr_priority_picker #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last_idx,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]   o_gnt_idx
);

`ifdef AVALON_ARB_FIXED_PRIO_EN
   logic unused_last_idx;
   assign unused_last_idx = ^i_last_idx;

   always_comb begin
      logic found;
      o_gnt     = '0;
      o_gnt_idx = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && i_req[i]) begin
            found     = 1'b1;
            o_gnt[i]  = 1'b1;
            o_gnt_idx = IDX_W'(i);
         end
      end
   end
`else
   // Search starts one past the previous winner so every requester gets a turn.
   always_comb begin
      logic found;
      int   cand;
      o_gnt     = '0;
      o_gnt_idx = '0;
      found     = 1'b0;
      cand      = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = (int'(i_last_idx) + off) % NUM_REQ;
         if (!found && i_req[cand]) begin
            found       = 1'b1;
            o_gnt[cand] = 1'b1;
            o_gnt_idx   = IDX_W'(cand);
         end
      end
   end
`endif

endmodule

// File: rtl/avalon_burst_arbiter.sv
// Grants one Avalon-MM burst slave to one of NUM_MASTERS masters per burst.
// Define AVALON_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
//
// state    | meaning
// ST_IDLE  | no command forwarded, all masters stalled, arbitrate pending requests
// ST_BURST | granted master owns the slave until its last beat is accepted
module avalon_burst_arbiter
   import avalon_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 30
) (
   input  logic                              i_Clk,
   input  logic                              i_Reset,
   input  logic [NUM_MASTERS*ADDR_W-1:0]     i_M_Addr,
   input  logic [NUM_MASTERS*AV_BE_W-1:0]    i_M_ByteEn,
   input  logic [NUM_MASTERS-1:0]            i_M_Read,
   input  logic [NUM_MASTERS-1:0]            i_M_Write,
   input  logic [NUM_MASTERS*AV_DATA_W-1:0]  i_M_WriteData,
   input  logic [NUM_MASTERS*AV_BURST_W-1:0] i_M_BurstCount,
   output logic [NUM_MASTERS*AV_DATA_W-1:0]  o_M_ReadData,
   output logic [NUM_MASTERS-1:0]            o_M_WaitRequest,
   output logic [ADDR_W-1:0]                 o_S_Addr,
   output logic [AV_BE_W-1:0]                o_S_ByteEn,
   output logic                              o_S_Read,
   output logic                              o_S_Write,
   output logic [AV_DATA_W-1:0]              o_S_WriteData,
   output logic [AV_BURST_W-1:0]             o_S_BurstCount,
   input  logic [AV_DATA_W-1:0]              i_S_ReadData,
   input  logic                              i_S_WaitRequest,
   output logic [NUM_MASTERS-1:0]            o_Grant
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   arb_state_e             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]       gidx_q, gidx_d;
   logic [AV_BURST_W-1:0]  burst_len_q, burst_len_d;
   logic [AV_BURST_W-1:0]  beat_q, beat_d;
   logic [IDX_W-1:0]       data_owner_q, data_owner_d;
   logic                   data_valid_q, data_valid_d;
`ifndef AVALON_ARB_FIXED_PRIO_EN
   logic [IDX_W-1:0]       last_grant_q, last_grant_d;
`endif

   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] pick_gnt;
   logic [IDX_W-1:0]       pick_idx;
   logic [IDX_W-1:0]       picker_last;
   logic [AV_BURST_W-1:0]  pick_bc;
   logic                   sel_read;
   logic                   sel_write;
   logic                   beat_accept;

   assign req = i_M_Read | i_M_Write;

`ifdef AVALON_ARB_FIXED_PRIO_EN
   assign picker_last = '0;
`else
   assign picker_last = last_grant_q;
`endif

   rr_priority_picker #(
      .NUM_REQ (NUM_MASTERS),
      .IDX_W   (IDX_W)
   ) u_picker (
      .i_req      (req),
      .i_last_idx (picker_last),
      .o_gnt      (pick_gnt),
      .o_gnt_idx  (pick_idx)
   );

   assign pick_bc   = i_M_BurstCount[int'(pick_idx)*AV_BURST_W +: AV_BURST_W];
   assign sel_read  = i_M_Read[gidx_q];
   assign sel_write = i_M_Write[gidx_q];

   // Command path is purely combinational so the owner sees slave stalls the same cycle.
   always_comb begin
      o_S_Addr        = '0;
      o_S_ByteEn      = '0;
      o_S_WriteData   = '0;
      o_S_BurstCount  = '0;
      o_S_Read        = 1'b0;
      o_S_Write       = 1'b0;
      o_M_WaitRequest = '1;
      if (state_q == ST_BURST) begin
         o_S_Addr                = i_M_Addr[int'(gidx_q)*ADDR_W +: ADDR_W];
         o_S_ByteEn              = i_M_ByteEn[int'(gidx_q)*AV_BE_W +: AV_BE_W];
         o_S_WriteData           = i_M_WriteData[int'(gidx_q)*AV_DATA_W +: AV_DATA_W];
         o_S_BurstCount          = i_M_BurstCount[int'(gidx_q)*AV_BURST_W +: AV_BURST_W];
         o_S_Write               = sel_write;
         o_S_Read                = sel_read & ~sel_write;
         o_M_WaitRequest[gidx_q] = i_S_WaitRequest;
      end
   end

   assign beat_accept = (o_S_Read | o_S_Write) & ~i_S_WaitRequest;

   always_comb begin
      o_M_ReadData = '0;
      if (data_valid_q) begin
         o_M_ReadData[int'(data_owner_q)*AV_DATA_W +: AV_DATA_W] = i_S_ReadData;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      gidx_d       = gidx_q;
      burst_len_d  = burst_len_q;
      beat_d       = beat_q;
      data_owner_d = data_owner_q;
      data_valid_d = 1'b0;
`ifndef AVALON_ARB_FIXED_PRIO_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               state_d     = ST_BURST;
               grant_d     = pick_gnt;
               gidx_d      = pick_idx;
               burst_len_d = (pick_bc == '0) ? AV_BURST_W'(1) : pick_bc;
               beat_d      = '0;
`ifndef AVALON_ARB_FIXED_PRIO_EN
               last_grant_d = pick_idx;
`endif
            end
         end
         ST_BURST: begin
            if (beat_accept) begin
               if (beat_q == burst_len_q - AV_BURST_W'(1)) begin
                  state_d = ST_IDLE;
                  grant_d = '0;
               end else begin
                  beat_d = beat_q + AV_BURST_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (beat_accept && o_S_Read) begin
         data_valid_d = 1'b1;
         data_owner_d = gidx_q;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         gidx_q       <= '0;
         burst_len_q  <= AV_BURST_W'(1);
         beat_q       <= '0;
         data_owner_q <= '0;
         data_valid_q <= 1'b0;
`ifndef AVALON_ARB_FIXED_PRIO_EN
         last_grant_q <= IDX_W'(NUM_MASTERS - 1);
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         gidx_q       <= gidx_d;
         burst_len_q  <= burst_len_d;
         beat_q       <= beat_d;
         data_owner_q <= data_owner_d;
         data_valid_q <= data_valid_d;
`ifndef AVALON_ARB_FIXED_PRIO_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign o_Grant = grant_q;

endmodule

// File: tb/tb_avalon_burst_arbiter.sv
// Bench for avalon_burst_arbiter (2 masters) with a per-cycle reference model.
module tb_avalon_burst_arbiter;

   localparam int N  = 2;
   localparam int AW = 30;

   logic            clk;
   logic            i_Reset;
   logic [N*AW-1:0] i_M_Addr;
   logic [N*4-1:0]  i_M_ByteEn;
   logic [N-1:0]    i_M_Read;
   logic [N-1:0]    i_M_Write;
   logic [N*32-1:0] i_M_WriteData;
   logic [N*8-1:0]  i_M_BurstCount;
   logic [N*32-1:0] o_M_ReadData;
   logic [N-1:0]    o_M_WaitRequest;
   logic [AW-1:0]   o_S_Addr;
   logic [3:0]      o_S_ByteEn;
   logic            o_S_Read;
   logic            o_S_Write;
   logic [31:0]     o_S_WriteData;
   logic [7:0]      o_S_BurstCount;
   logic [31:0]     i_S_ReadData;
   logic            i_S_WaitRequest;
   logic [N-1:0]    o_Grant;

   avalon_burst_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW)) dut (
      .i_Clk           (clk),
      .i_Reset         (i_Reset),
      .i_M_Addr        (i_M_Addr),
      .i_M_ByteEn      (i_M_ByteEn),
      .i_M_Read        (i_M_Read),
      .i_M_Write       (i_M_Write),
      .i_M_WriteData   (i_M_WriteData),
      .i_M_BurstCount  (i_M_BurstCount),
      .o_M_ReadData    (o_M_ReadData),
      .o_M_WaitRequest (o_M_WaitRequest),
      .o_S_Addr        (o_S_Addr),
      .o_S_ByteEn      (o_S_ByteEn),
      .o_S_Read        (o_S_Read),
      .o_S_Write       (o_S_Write),
      .o_S_WriteData   (o_S_WriteData),
      .o_S_BurstCount  (o_S_BurstCount),
      .i_S_ReadData    (i_S_ReadData),
      .i_S_WaitRequest (i_S_WaitRequest),
      .o_Grant         (o_Grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: owner (-1 = idle), beats left, next round-robin start, pending read owner.
   int m_owner = -1;
   int m_left  = 0;
   int m_rr    = 0;
   int m_pend  = -1;

   always @(negedge clk) begin
      logic [N-1:0]    eg, ew, req;
      logic            esr, esw, acc;
      logic [N*32-1:0] erd;
      int              w, bc;
      eg  = '0;
      ew  = '1;
      esr = 1'b0;
      esw = 1'b0;
      erd = '0;
      if (m_pend >= 0) erd[m_pend*32 +: 32] = i_S_ReadData;
      if (m_owner >= 0) begin
         eg[m_owner] = 1'b1;
         esw         = i_M_Write[m_owner];
         esr         = i_M_Read[m_owner] && !i_M_Write[m_owner];
         ew[m_owner] = i_S_WaitRequest;
      end
      check("grant", 64'(o_Grant), 64'(eg));
      check("m_wait", 64'(o_M_WaitRequest), 64'(ew));
      check("s_read", 64'(o_S_Read), 64'(esr));
      check("s_write", 64'(o_S_Write), 64'(esw));
      check("m_rdata", 64'(o_M_ReadData), 64'(erd));
      if (m_owner >= 0) begin
         check("s_addr", 64'(o_S_Addr), 64'(i_M_Addr[m_owner*AW +: AW]));
         check("s_be", 64'(o_S_ByteEn), 64'(i_M_ByteEn[m_owner*4 +: 4]));
         check("s_wdata", 64'(o_S_WriteData), 64'(i_M_WriteData[m_owner*32 +: 32]));
         check("s_bc", 64'(o_S_BurstCount), 64'(i_M_BurstCount[m_owner*8 +: 8]));
      end
      acc = (esr || esw) && !i_S_WaitRequest;
      req = i_M_Read | i_M_Write;
      if (i_Reset) begin
         m_owner = -1;
         m_left  = 0;
         m_rr    = 0;
         m_pend  = -1;
      end else begin
         m_pend = (acc && esr) ? m_owner : -1;
         if (m_owner < 0) begin
            w = -1;
`ifdef AVALON_ARB_FIXED_PRIO_EN
            for (int i = N - 1; i >= 0; i--) if (req[i]) w = i;
`else
            for (int k = 0; k < N; k++) if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
`endif
            if (w >= 0) begin
               bc      = int'(i_M_BurstCount[w*8 +: 8]);
               m_owner = w;
               m_left  = (bc == 0) ? 1 : bc;
               m_rr    = (w + 1) % N;
            end
         end else if (acc) begin
            m_left--;
            if (m_left == 0) m_owner = -1;
         end
      end
   end

   // Per-cycle logs and a simple slave that answers accepted reads with 0xA0+n.
   logic [N-1:0]    g_log[$];
   logic [N-1:0]    w_log[$];
   logic [N*32-1:0] rd_log[$];
   int acc_cnt, wr_beats, rd_cnt, cyc;

   task automatic clear_logs();
      g_log.delete();
      w_log.delete();
      rd_log.delete();
      acc_cnt  = 0;
      wr_beats = 0;
      rd_cnt   = 0;
   endtask

   task automatic tick();
      logic acc, acc_rd;
      #2;
      acc    = (o_S_Read | o_S_Write) & ~i_S_WaitRequest & ~i_Reset;
      acc_rd = acc & o_S_Read;
      if (acc) acc_cnt++;
      if (acc && o_S_Write) wr_beats++;
      g_log.push_back(o_Grant);
      w_log.push_back(o_M_WaitRequest);
      rd_log.push_back(o_M_ReadData);
      @(posedge clk);
      #1;
      cyc++;
      if (acc_rd) begin
         i_S_ReadData = 32'hA0 + 32'(rd_cnt);
         rd_cnt++;
      end else begin
         i_S_ReadData = 32'hDEAD_0000 + 32'(cyc);
      end
   endtask

   task automatic set_m(input int k, input logic rd, input logic wr, input logic [AW-1:0] addr,
                        input logic [7:0] bc, input logic [31:0] wd);
      i_M_Read[k]             = rd;
      i_M_Write[k]            = wr;
      i_M_Addr[k*AW +: AW]    = addr;
      i_M_ByteEn[k*4 +: 4]    = 4'hF ^ 4'(k);
      i_M_BurstCount[k*8 +: 8] = bc;
      i_M_WriteData[k*32 +: 32] = wd;
   endtask

   task automatic do_reset();
      i_Reset = 1'b1;
      i_M_Read = '0;
      i_M_Write = '0;
      i_S_WaitRequest = 1'b0;
      tick();
      tick();
      i_Reset = 1'b0;
      check("rst_grant", 64'(g_log[g_log.size()-1]), 64'h0);
      check("rst_wait", 64'(w_log[w_log.size()-1]), 64'h3);
      check("rst_rdata", 64'(rd_log[rd_log.size()-1]), 64'h0);
      clear_logs();
   endtask

   initial begin
      int n10;
      i_Reset = 1'b1;
      i_M_Addr = '0;
      i_M_ByteEn = '0;
      i_M_Read = '0;
      i_M_Write = '0;
      i_M_WriteData = '0;
      i_M_BurstCount = '0;
      i_S_ReadData = '0;
      i_S_WaitRequest = 1'b0;
      cyc = 0;
      clear_logs();
      @(posedge clk);
      #1;
      do_reset();

      // Reset in the middle of a 4-beat write burst
      set_m(0, 1'b0, 1'b1, 30'h0, 8'd4, 32'h1111_0000);
      tick();
      tick();
      tick();
      i_Reset = 1'b1;
      tick();
      i_Reset = 1'b0;
      i_M_Write = '0;
      tick();
      check("t1_slave_beats", 64'(wr_beats), 64'd2);
      check("t1_grant_after", 64'(g_log[4]), 64'h0);
      check("t1_wait_after", 64'(w_log[4]), 64'h3);
      check("t1_rdata_after", 64'(rd_log[4]), 64'h0);

      do_reset();
      // 4-beat read burst from M0
      set_m(0, 1'b1, 1'b0, 30'h0, 8'd4, 32'h0);
      for (int g = 0; g < 20 && acc_cnt < 4; g++) tick();
      check("t2_beats", 64'(acc_cnt), 64'd4);
      set_m(0, 1'b0, 1'b0, 30'h0, 8'd4, 32'h0);
      tick();
      tick();
      check("t2_grant_c0", 64'(g_log[0]), 64'h0);
      for (int c = 1; c <= 4; c++) check("t2_grant", 64'(g_log[c]), 64'h1);
      check("t2_rd0_c1", 64'(rd_log[1][31:0]), 64'h0);
      for (int c = 2; c <= 5; c++) check("t2_rd0", 64'(rd_log[c][31:0]), 64'(32'hA0 + 32'(c - 2)));
      check("t2_rd0_c6", 64'(rd_log[6][31:0]), 64'h0);
      for (int c = 0; c <= 6; c++) check("t2_rd1", 64'(rd_log[c][63:32]), 64'h0);

      do_reset();
      // Both masters streaming single-beat writes
      set_m(0, 1'b0, 1'b1, 30'h100, 8'd1, 32'hAAAA_0000);
      set_m(1, 1'b0, 1'b1, 30'h200, 8'd1, 32'hBBBB_0000);
      for (int c = 0; c < 8; c++) tick();
      i_M_Write = '0;
      tick();
      for (int c = 0; c < 8; c++) begin
         logic [N-1:0] eg;
         if (c % 2 == 0) eg = 2'b00;
`ifdef AVALON_ARB_FIXED_PRIO_EN
         else eg = 2'b01;
`else
         else eg = (((c - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10;
`endif
         check("t3_grant_seq", 64'(g_log[c]), 64'(eg));
      end

      do_reset();
      // M1 2-beat write with slave stalling the first beat for 3 cycles; M0 waits behind it
      set_m(1, 1'b0, 1'b1, 30'h300, 8'd2, 32'hCCCC_0001);
      tick();
      i_S_WaitRequest = 1'b1;
      set_m(0, 1'b1, 1'b0, 30'h40, 8'd1, 32'h0);
      tick();
      tick();
      tick();
      i_S_WaitRequest = 1'b0;
      tick();
      tick();
      i_M_Write[1] = 1'b0;
      tick();
      tick();
      i_M_Read[0] = 1'b0;
      tick();
      tick();
      check("t4_accepts", 64'(acc_cnt), 64'd3);
      check("t4_wr_beats", 64'(wr_beats), 64'd2);
      n10 = 0;
      for (int c = 0; c < 10; c++) if (g_log[c] == 2'b10) n10++;
      check("t4_cmd_cycles", 64'(n10), 64'd5);
      for (int c = 1; c <= 5; c++) check("t4_wait1", 64'(w_log[c][1]), 64'(c <= 3));
      for (int c = 0; c <= 6; c++) check("t4_wait0", 64'(w_log[c][0]), 64'h1);
      check("t4_grant_m0", 64'(g_log[7]), 64'h1);

      do_reset();
      // BurstCount 0 with read and write both asserted
      set_m(0, 1'b1, 1'b1, 30'h55, 8'd0, 32'h5555_5555);
      tick();
      tick();
      set_m(0, 1'b0, 1'b0, 30'h55, 8'd0, 32'h5555_5555);
      tick();
      check("t5_grant_c1", 64'(g_log[1]), 64'h1);
      check("t5_grant_c2", 64'(g_log[2]), 64'h0);
      check("t5_accepts", 64'(acc_cnt), 64'd1);
      check("t5_write_won", 64'(wr_beats), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
